// File: rtl/jk_floor_stepper.sv
// Floor-register stepper: walks a bank of JK flip-flops one floor per step toward a
// requested floor and verifies each step against the bank's q outputs. Optional macro JK_TOGGLE_CODE_EN.
module jk_floor_stepper #(
    parameter int WIDTH       = 2,
    parameter int MAX_FLOOR   = 3,
    parameter int STEP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_floor,
    output logic             req_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic [WIDTH-1:0] jk_en,
    output logic             moving,
    output logic             dir_up,
    output logic             arrived,
    output logic             rejected,
    output logic             err
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [WIDTH-1:0] MAX_F = WIDTH'(MAX_FLOOR);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_STEP, S_CHECK, S_DWELL, S_FAULT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d, expected_q, expected_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] jk_j_q, jk_j_d, jk_k_q, jk_k_d, jk_en_q, jk_en_d;
    logic             req_ready_q, req_ready_d, moving_q, moving_d, dir_up_q, dir_up_d;
    logic             arrived_q, arrived_d, rejected_q, rejected_d, err_q, err_d;
    logic             go_step;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        expected_d = expected_q;
        cnt_d      = cnt_q;
        moving_d   = moving_q;
        dir_up_d   = dir_up_q;
        err_d      = err_q;
        arrived_d  = 1'b0;
        rejected_d = 1'b0;
        go_step    = 1'b0;
        jk_j_d     = '0;
        jk_k_d     = '0;
        jk_en_d    = '0;
        nxt        = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_floor > MAX_F) begin
                        rejected_d = 1'b1;
                    end else if (req_floor == q_fb) begin
                        arrived_d = 1'b1;
                    end else begin
                        target_d = req_floor;
                        dir_up_d = (req_floor > q_fb);
                        moving_d = 1'b1;
                        go_step  = 1'b1;
                        state_d  = S_STEP;
                    end
                end
            end
            S_STEP:  state_d = S_CHECK;
            S_CHECK: begin
                if (q_fb != expected_q) begin
                    err_d    = 1'b1;
                    moving_d = 1'b0;
                    state_d  = S_FAULT;
                end else if (q_fb == target_q) begin
                    arrived_d = 1'b1;
                    moving_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d   = DWELL_LOAD;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (cnt_q == '0) begin
                    go_step = 1'b1;
                    state_d = S_STEP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_FAULT;
        endcase

        // Excitation is registered, so it is computed on the edge that enters STEP.
        if (go_step) begin
            nxt        = dir_up_d ? q_fb + 1'b1 : q_fb - 1'b1;
            expected_d = nxt;
`ifdef JK_TOGGLE_CODE_EN
            jk_j_d  = q_fb ^ nxt;
            jk_k_d  = q_fb ^ nxt;
            jk_en_d = q_fb ^ nxt;
`else
            jk_j_d  = ~q_fb & nxt;
            jk_k_d  = q_fb & ~nxt;
            jk_en_d = '1;
`endif
        end

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            expected_q  <= '0;
            cnt_q       <= '0;
            jk_j_q      <= '0;
            jk_k_q      <= '0;
            jk_en_q     <= '0;
            req_ready_q <= 1'b0;
            moving_q    <= 1'b0;
            dir_up_q    <= 1'b0;
            arrived_q   <= 1'b0;
            rejected_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            expected_q  <= expected_d;
            cnt_q       <= cnt_d;
            jk_j_q      <= jk_j_d;
            jk_k_q      <= jk_k_d;
            jk_en_q     <= jk_en_d;
            req_ready_q <= req_ready_d;
            moving_q    <= moving_d;
            dir_up_q    <= dir_up_d;
            arrived_q   <= arrived_d;
            rejected_q  <= rejected_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign jk_j      = jk_j_q;
    assign jk_k      = jk_k_q;
    assign jk_en     = jk_en_q;
    assign moving    = moving_q;
    assign dir_up    = dir_up_q;
    assign arrived   = arrived_q;
    assign rejected  = rejected_q;
    assign err       = err_q;
endmodule

// File: tb/tb_jk_floor_stepper.sv
// Bench for jk_floor_stepper: behavioural JK bank, vector table, random moves, reset/fault corners.
module tb_jk_floor_stepper;
    localparam int S = 4;
    localparam int P = S + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid, req_ready, moving, dir_up, arrived, rejected, err;
    logic [1:0] req_floor, q_fb, jk_j, jk_k, jk_en;
    logic       r_valid, r_ready, r_moving, r_dir, r_arrived, r_rejected, r_err;
    logic [1:0] r_floor, r_j, r_k, r_en;
    logic [1:0] r_q = 2'd1;

    logic       load_en, fault_mode;
    logic [1:0] load_val;

    int checks = 0;
    int failures = 0;

    jk_floor_stepper #(.WIDTH(2), .MAX_FLOOR(3), .STEP_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready),
        .q_fb(q_fb), .jk_j(jk_j), .jk_k(jk_k), .jk_en(jk_en), .moving(moving), .dir_up(dir_up),
        .arrived(arrived), .rejected(rejected), .err(err));

    jk_floor_stepper #(.WIDTH(2), .MAX_FLOOR(2), .STEP_CYCLES(S)) dut_max2 (
        .clk(clk), .rst(rst), .req_valid(r_valid), .req_floor(r_floor), .req_ready(r_ready),
        .q_fb(r_q), .jk_j(r_j), .jk_k(r_k), .jk_en(r_en), .moving(r_moving), .dir_up(r_dir),
        .arrived(r_arrived), .rejected(r_rejected), .err(r_err));

    // Behavioural JK bank: enabled bits follow the JK truth table at each rising edge.
    always @(posedge clk) begin
        if (load_en) q_fb <= load_val;
        else if (!fault_mode) begin
            for (int i = 0; i < 2; i++) begin
                if (jk_en[i]) begin
                    case ({jk_j[i], jk_k[i]})
                        2'b01:   q_fb[i] <= 1'b0;
                        2'b10:   q_fb[i] <= 1'b1;
                        2'b11:   q_fb[i] <= ~q_fb[i];
                        default: q_fb[i] <= q_fb[i];
                    endcase
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected excitation for one floor transition, returned as {j, k, en}.
    function automatic logic [5:0] ref_jk(input logic [1:0] cur, input logic [1:0] nxt);
        logic [1:0] j, k, en;
        j = '0; k = '0; en = '0;
        for (int i = 0; i < 2; i++) begin
`ifdef JK_TOGGLE_CODE_EN
            if (cur[i] != nxt[i]) begin j[i] = 1'b1; k[i] = 1'b1; en[i] = 1'b1; end
`else
            en[i] = 1'b1;
            if (!cur[i] && nxt[i]) j[i] = 1'b1;
            if (cur[i] && !nxt[i]) k[i] = 1'b1;
`endif
        end
        return {j, k, en};
    endfunction

    task automatic load_floor(input logic [1:0] f);
        @(negedge clk); load_en = 1'b1; load_val = f;
        @(posedge clk); #1 load_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] f);
        @(negedge clk);
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_floor = f;
        @(posedge clk); #1 req_valid = 1'b0;
    endtask

    // Sample c is taken on the falling edge c cycles after the accept edge.
    task automatic run_move(input logic [1:0] start, input logic [1:0] target, input int steps, input logic dir);
        int arr;
        logic [1:0] from, to;
        logic [5:0] e;
        load_floor(start);
        issue(target);
        arr = (steps == 0) ? 0 : 2 + (steps - 1) * P;
        for (int c = 0; c <= arr + 2; c++) begin
            @(negedge clk);
            e = '0;
            if (steps > 0 && (c % P) == 0 && (c / P) < steps) begin
                from = dir ? start + 2'(c / P) : start - 2'(c / P);
                to   = dir ? from + 2'd1 : from - 2'd1;
                e    = ref_jk(from, to);
            end
            chk("jk_j", 32'(jk_j), 32'(e[5:4]));
            chk("jk_k", 32'(jk_k), 32'(e[3:2]));
            chk("jk_en", 32'(jk_en), 32'(e[1:0]));
            chk("arrived", 32'(arrived), 32'(c == arr));
            chk("moving", 32'(moving), 32'(steps > 0 && c < arr));
            if (steps > 0 && c < arr) chk("dir_up", 32'(dir_up), 32'(dir));
        end
        chk("final_floor", 32'(q_fb), 32'(target));
        chk("ready_after", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic [1:0] start;
        logic [1:0] target;
        int         steps;
        logic       dir;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [1:0] s, t;
        vecs[0] = '{2'd0, 2'd2, 2, 1'b1};
        vecs[1] = '{2'd3, 2'd0, 3, 1'b0};
        vecs[2] = '{2'd1, 2'd1, 0, 1'b0};
        vecs[3] = '{2'd0, 2'd1, 1, 1'b1};
        vecs[4] = '{2'd2, 2'd3, 1, 1'b1};
        vecs[5] = '{2'd3, 2'd1, 2, 1'b0};

        req_valid = 1'b0; req_floor = '0; r_valid = 1'b0; r_floor = '0;
        fault_mode = 1'b0; load_en = 1'b1; load_val = 2'd0;

        // Reset state and release
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 32'({req_ready, jk_j, jk_k, jk_en, moving, dir_up, arrived, rejected, err}), 32'd0);
        rst = 1'b0; load_en = 1'b0;
        #1 chk("ready_low_pre_clk", 32'(req_ready), 32'd0);
        @(posedge clk); #1 chk("ready_after_release", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_move(vecs[i].start, vecs[i].target, vecs[i].steps, vecs[i].dir);

        for (int i = 0; i < 20; i++) begin
            s = 2'($urandom_range(0, 3));
            t = 2'($urandom_range(0, 3));
            run_move(s, t, (t > s) ? int'(t - s) : int'(s - t), t > s);
        end

        // Out-of-range and boundary requests on the MAX_FLOOR=2 instance
        @(negedge clk); r_valid = 1'b1; r_floor = 2'd3;
        @(posedge clk); #1 r_valid = 1'b0;
        @(negedge clk);
        chk("rej_pulse", 32'(r_rejected), 32'd1);
        chk("rej_no_arrive", 32'(r_arrived), 32'd0);
        chk("rej_stays_idle", 32'({r_ready, r_moving, r_en}), 32'(4'b1000));
        @(negedge clk); chk("rej_one_cycle", 32'(r_rejected), 32'd0);
        r_valid = 1'b1; r_floor = 2'd1;
        @(posedge clk); #1 r_valid = 1'b0;
        @(negedge clk); chk("same_floor_arrive", 32'({r_arrived, r_en, r_rejected}), 32'(4'b1000));
        r_valid = 1'b1; r_floor = 2'd2;
        @(posedge clk); #1 r_valid = 1'b0;
        @(negedge clk); chk("max_floor_accepted", 32'({r_rejected, r_moving}), 32'(2'b01));

        // Feedback fault: bank ignores the first step
        load_floor(2'd0);
        fault_mode = 1'b1;
        issue(2'd2);
        @(negedge clk); chk("fault_step_en", 32'(jk_en), 32'(2'b11));
        @(negedge clk); chk("fault_no_err_yet", 32'(err), 32'd0);
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            chk("fault_err", 32'(err), 32'd1);
            chk("fault_idle_outs", 32'({req_ready, moving, jk_en, arrived}), 32'd0);
            req_valid = 1'b1; req_floor = 2'd1;
        end
        req_valid = 1'b0; fault_mode = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1 chk("fault_cleared_by_rst", 32'({err, r_err}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk);

        // Reset during DWELL aborts, then a fresh move completes
        load_floor(2'd0);
        issue(2'd3);
        repeat (4) @(negedge clk);
        chk("dwell_moving", 32'(moving), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_midmove", 32'({moving, req_ready, jk_en, dir_up}), 32'd0);
        chk("floor_after_abort", 32'(q_fb), 32'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk);
        run_move(2'd1, 2'd3, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
